// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and constants shared by the UART transmitter
// and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake into the UART transmitter.
// The master offers bytes and the slave (uart_tx) accepts them.
interface uart_tx_if import uart_pkg::*; ();

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16-bit bit-period counter; bit_tick marks the last
// clk of each serial bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    assign bit_tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_tick ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter with valid/ready byte input.
// Define UART_TX_PARITY_EN to add an even parity bit after the data.
module uart_tx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  up,
    output logic      tx,
    output logic      tx_done
);

    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t state, state_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  sh, sh_d;
    logic        tx_d;
    logic        bit_tick;
    logic        accept;
`ifdef UART_TX_PARITY_EN
    logic        par, par_d;
`endif

    assign accept  = up.tx_valid && up.tx_ready;
    assign tx_done = (state == UART_STOP) && bit_tick
                     && (idx == LAST_STOP);
    // Ready in the final stop clk lets frames run with no idle gap.
    assign up.tx_ready = (state == UART_IDLE) || tx_done;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (state != UART_IDLE),
        .clr      (accept),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UART_IDLE;
            idx   <= '0;
            sh    <= '0;
            tx    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            idx   <= idx_d;
            sh    <= sh_d;
            tx    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        sh_d    = sh;
        tx_d    = tx;
`ifdef UART_TX_PARITY_EN
        par_d   = par;
`endif
        unique case (state)
            UART_IDLE: begin
                if (accept) begin
                    state_d = UART_START;
                    sh_d    = up.tx_data;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            UART_START: begin
                if (bit_tick) begin
                    state_d = UART_DATA;
                    tx_d    = sh[0];
`ifdef UART_TX_PARITY_EN
                    par_d   = sh[0];
`endif
                end
            end
            UART_DATA: begin
                if (bit_tick) begin
                    if (idx == LAST_DATA) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = UART_PARITY;
                        tx_d    = par;
`else
                        state_d = UART_STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        idx_d = idx + 3'd1;
                        sh_d  = {1'b0, sh[7:1]};
                        tx_d  = sh[1];
`ifdef UART_TX_PARITY_EN
                        par_d = par ^ sh[1];
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: begin
                if (bit_tick) begin
                    state_d = UART_STOP;
                    idx_d   = '0;
                    tx_d    = UART_IDLE_LEVEL;
                end
            end
`endif
            UART_STOP: begin
                if (bit_tick) begin
                    if (idx == LAST_STOP) begin
                        if (accept) begin
                            state_d = UART_START;
                            sh_d    = up.tx_data;
                            idx_d   = '0;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = UART_IDLE;
                            tx_d    = UART_IDLE_LEVEL;
                        end
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_d = UART_IDLE;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

endmodule
